// File: rtl/booth_seq_mult.sv
// booth_seq_mult
// Sequential radix-2 Booth multiplier. One add/subtract cycle (CALC) and one
// arithmetic-shift cycle (SHIFT) per multiplier bit, so the product is ready
// 2*WIDTH cycles after the start edge. The result is handed over on a
// done/result_ack handshake.
//
// Ports:
//   clk           system clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   start         begin a multiplication (sampled only in IDLE)
//   multiplicand  signed operand M, captured on an accepted start
//   multiplier    signed operand Q, captured on an accepted start
//   busy          high in every state except IDLE
//   done          product valid, held until result_ack
//   result_ack    consumer acknowledge, only meaningful while done=1
//   product       signed 2*WIDTH-bit product M*Q
module booth_seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   input  logic                 result_ack,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state;

   // A and M carry one extra sign bit so that negating -2^(WIDTH-1) cannot
   // overflow.
   logic signed [WIDTH:0] acc;
   logic signed [WIDTH:0] mcand;
   logic [WIDTH-1:0]      q;
   logic                  q_m1;
   logic [CW-1:0]         count;

   logic                  load_en;
   logic                  shift_en;
   logic signed [WIDTH:0] acc_sh;
   logic [WIDTH-1:0]      q_sh;

   // One Booth recoding step on the pair {Q[0], Q-1}.
   function automatic logic signed [WIDTH:0] booth_step(
      input logic signed [WIDTH:0] a,
      input logic signed [WIDTH:0] m,
      input logic [1:0]            sel
   );
      case (sel)
         2'b10:   return a - m;
         2'b01:   return a + m;
         default: return a;
      endcase
   endfunction

   // Load (operand capture or A update) always wins over shift; the state
   // encoding already keeps them apart, the priority is just a safeguard.
   always_comb begin
      load_en  = ((state == S_IDLE) && start) || (state == S_CALC);
      shift_en = (state == S_SHIFT) && !load_en;
   end

   // Arithmetic right shift of {A, Q, Q-1}: A's LSB feeds Q's MSB.
   always_comb begin
      acc_sh = acc >>> 1;
      q_sh   = {acc[0], q[WIDTH-1:1]};
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         mcand <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
      end else if (load_en) begin
         if (state == S_IDLE) begin
            mcand <= {multiplicand[WIDTH-1], multiplicand};
            q     <= multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
         end else begin
            acc <= booth_step(acc, mcand, {q[0], q_m1});
         end
      end else if (shift_en) begin
         acc  <= acc_sh;
         q    <= q_sh;
         q_m1 <= q[0];
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  count <= CW'(WIDTH);
                  busy  <= 1'b1;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  // Low 2*WIDTH bits of the post-shift {A, Q}.
                  product <= {acc_sh[WIDTH-1:0], q_sh};
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  state <= S_CALC;
               end
            end
            S_DONE: begin
               if (result_ack) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Sequential radix-2 Booth multiplier core: control FSM, iteration counter, add/subtract unit and the A/Q/Q-1 shift registers.
- Sits directly downstream of operand capture. It drives the load/shift enables of the accumulator (A) and multiplier (Q) shift registers, feeding A's LSB into Q's shift-in.
- Presents the signed 2*WIDTH-bit product to the consumer over a done/ack handshake.

Parameters:
- WIDTH, 8, operand width in bits (signed two's complement); legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a multiplication; sampled only in IDLE
- multiplicand  input  WIDTH  signed operand M; captured on an accepted start
- multiplier  input  WIDTH  signed operand Q; captured on an accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  product valid; held until acknowledged
- result_ack  input  1  consumer acknowledges the product; meaningful only while done=1
- product  output  2*WIDTH  signed result M*Q

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; done=0; product=0.
  - A, Q, q_m1 and count are cleared.
  - Reset asserted mid-operation aborts immediately, with no partial result.
- Internal widths:
  - A and M are held sign-extended to WIDTH+1 bits, so the most negative multiplicand (-2^(WIDTH-1)) negates without overflow.
  - Q is WIDTH bits; q_m1 is 1 bit.
  - count is ceil(log2(WIDTH+1)) bits.
- States: IDLE, CALC, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: capture M (sign-extended) and Q; A=0, q_m1=0, count=WIDTH; go to CALC.
  - start=0: stay in IDLE.
- CALC (one cycle): select on {Q[0], q_m1}:
  - 2'b10: A = A - M
  - 2'b01: A = A + M
  - 2'b00 or 2'b11: A unchanged
  - Addition is modulo 2^(WIDTH+1). Go to SHIFT.
- SHIFT (one cycle):
  - Arithmetic right shift of {A, Q, q_m1} by one: A MSB replicated, A[0] -> Q[WIDTH-1], Q[0] -> q_m1.
  - count decrements by 1.
  - If count was 1 before the decrement, go to DONE; otherwise go to CALC.
- DONE:
  - done=1; product = {A[WIDTH-1:0], Q}, i.e. the low 2*WIDTH bits of the WIDTH+1+WIDTH result.
  - product is held stable while done=1.
  - result_ack=1 at an edge: go to IDLE, done=0. product retains its value until the next accepted start.
- Latency:
  - Take the edge at which start is sampled as edge 0.
  - done rises after edge 2*WIDTH (16 edges for WIDTH=8).
  - busy rises after edge 0.
- Simultaneous and boundary events:
  - start while busy (CALC, SHIFT or DONE) is ignored; no queuing.
  - start on the same edge as result_ack is ignored; the next start is accepted only in IDLE, i.e. at least one cycle after ack.
  - result_ack outside DONE has no effect.
  - Operand inputs may change freely after the start edge; only the captured values are used.
  - Zero operands still run the full 2*WIDTH cycles (no early termination).
- Enables: load and shift enables to A/Q are mutually exclusive in every cycle; load takes priority if both are ever requested.

Test Plan:
- Reset mid-run: start with 7*3, pull rst_n low after edge 5 -> busy=0, done=0, product=0 immediately; a fresh start 7*3 -> product=21, done after edge 16.
- WIDTH=8, M=3, Q=-4 (0xFC), start at edge 0:
  - busy=1 from edge 0.
  - done=1 after edge 16 with product=0xFFF4 (-12).
  - done held while ack=0; done=0 one edge after ack.
- Corner operands:
  - M=-128, Q=-128 -> product=0x4000 (16384).
  - M=-128, Q=127 -> product=0xC080 (-16256).
  - M=0, Q=-1 -> product=0x0000, still 16-cycle latency.
- start pulsed in CALC, SHIFT and DONE, and on the same edge as result_ack -> ignored: no operand recapture, product unchanged, state returns to IDLE only via ack.
- Randomized: 1000 random signed 8-bit pairs with random ack delay of 0..5 cycles -> every product equals the reference M*Q; busy/done never both low while the FSM is outside IDLE.
